// File: rtl/mul_pkg.sv
// Shared defaults and operand/product types for the pipelined signed multiplier.
package mul_pkg;
  localparam int MUL_A_W_DEF = 8;
  localparam int MUL_B_W_DEF = 8;
  localparam int MUL_LAT_DEF = 3;
  localparam int MUL_LAT_MAX = 8;

  typedef logic signed [MUL_A_W_DEF-1:0]             mul_a_t;
  typedef logic signed [MUL_B_W_DEF-1:0]             mul_b_t;
  typedef logic signed [MUL_A_W_DEF+MUL_B_W_DEF-1:0] mul_p_t;
endpackage

// File: rtl/mul_pipe_reg.sv
// Single pipeline register: synchronous active-high reset, reset wins over enable.
module mul_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mul.sv
// Pipelined full-precision signed multiplier, P_0 = A_0 * B_0 after LATENCY enabled edges.
// Optional valid side-band enabled by defining MUL_VALID_EN.
module mul
  import mul_pkg::*;
#(
  parameter int A_W     = MUL_A_W_DEF,
  parameter int B_W     = MUL_B_W_DEF,
  parameter int LATENCY = MUL_LAT_DEF
) (
  input  logic                     CLK_0,
  input  logic                     RST_0,
  input  logic                     CE_0,
  input  logic signed [A_W-1:0]    A_0,
  input  logic signed [B_W-1:0]    B_0,
`ifdef MUL_VALID_EN
  input  logic                     VLD_IN_0,
  output logic                     VLD_OUT_0,
`endif
  output logic signed [A_W+B_W-1:0] P_0
);
  localparam int P_W = A_W + B_W;
  // With LATENCY==1 the single register holds the product of the raw inputs.
  localparam int NPS = (LATENCY > 1) ? LATENCY - 1 : 1;

  if (LATENCY < 1 || LATENCY > MUL_LAT_MAX) begin : g_lat_chk
    $error("mul: LATENCY %0d outside 1..%0d", LATENCY, MUL_LAT_MAX);
  end

  logic signed [A_W-1:0] a_m;
  logic signed [B_W-1:0] b_m;
  logic signed [P_W-1:0] a_x, b_x, prod;
  logic        [P_W-1:0] pipe [NPS+1];

  if (LATENCY > 1) begin : g_opnd
    logic [P_W-1:0] opnd_q;
    mul_pipe_reg #(.W(P_W)) u_opnd (
      .clk(CLK_0), .rst(RST_0), .en(CE_0), .d({A_0, B_0}), .q(opnd_q)
    );
    assign a_m = opnd_q[P_W-1:B_W];
    assign b_m = opnd_q[B_W-1:0];
  end else begin : g_no_opnd
    assign a_m = A_0;
    assign b_m = B_0;
  end

  // Sign-extend to full product width; the result is exact, no overflow.
  assign a_x     = P_W'(a_m);
  assign b_x     = P_W'(b_m);
  assign prod    = a_x * b_x;
  assign pipe[0] = prod;

  for (genvar i = 0; i < NPS; i++) begin : g_prod
    mul_pipe_reg #(.W(P_W)) u_reg (
      .clk(CLK_0), .rst(RST_0), .en(CE_0), .d(pipe[i]), .q(pipe[i+1])
    );
  end

  assign P_0 = pipe[NPS];

`ifdef MUL_VALID_EN
  logic [LATENCY:0] vld_pipe;
  assign vld_pipe[0] = VLD_IN_0;
  for (genvar i = 0; i < LATENCY; i++) begin : g_vld
    mul_pipe_reg #(.W(1)) u_vld (
      .clk(CLK_0), .rst(RST_0), .en(CE_0), .d(vld_pipe[i]), .q(vld_pipe[i+1])
    );
  end
  assign VLD_OUT_0 = vld_pipe[LATENCY];
`endif
endmodule

// File: tb/tb_mul.sv
// Randomized self-checking bench for mul against a queue-based delay-line model.
module tb_mul;
  import mul_pkg::*;
  localparam int A_W = MUL_A_W_DEF;
  localparam int B_W = MUL_B_W_DEF;
  localparam int LAT = MUL_LAT_DEF;
  localparam int P_W = A_W + B_W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ce  = 1'b0;
  logic [A_W-1:0] a   = '0;
  logic [B_W-1:0] b   = '0;
  logic           vin = 1'b0;
  logic [P_W-1:0] p;
`ifdef MUL_VALID_EN
  logic           vout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul #(.A_W(A_W), .B_W(B_W), .LATENCY(LAT)) dut (
    .CLK_0(clk), .RST_0(rst), .CE_0(ce), .A_0(a), .B_0(b),
`ifdef MUL_VALID_EN
    .VLD_IN_0(vin), .VLD_OUT_0(vout),
`endif
    .P_0(p)
  );

  typedef struct packed {
    logic [P_W-1:0] p;
    logic           v;
  } ent_t;

  ent_t q[$];
  ent_t cur;

  logic [A_W-1:0] da [4] = '{8'h4F, 8'h80, 8'h80, 8'h0F};
  logic [B_W-1:0] db [4] = '{8'h6C, 8'h80, 8'h7F, 8'h80};
  logic [P_W-1:0] de [4] = '{16'h2154, 16'h4000, 16'hC080, 16'hF880};
  logic [P_W-1:0] held;
  logic [A_W-1:0] pa;
  logic [B_W-1:0] pb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] x, input logic [B_W-1:0] y);
    int xi, yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    return P_W'(xi * yi);
  endfunction

  task automatic mdl_reset();
    q.delete();
    for (int i = 0; i < LAT - 1; i++) q.push_back('0);
    cur = '0;
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (rst) mdl_reset();
    else if (ce) begin
      e.p = ref_mul(a, b);
      e.v = vin;
      q.push_back(e);
      cur = q.pop_front();
    end
    #1;
    chk("p", 32'(p), 32'(cur.p));
`ifdef MUL_VALID_EN
    chk("vld", 32'(vout), 32'(cur.v));
`endif
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = A_W'($urandom); b = B_W'($urandom); vin = 1'($urandom);
      tick();
      chk("rst_hold", 32'(p), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 4 + LAT; i++) begin
      if (i < 4) begin a = da[i]; b = db[i]; vin = 1'b1; end
      else       begin a = '0;    b = '0;    vin = 1'b0; end
      tick();
      if (i >= LAT - 1 && i - (LAT - 1) < 4) chk("directed", 32'(p), 32'(de[i-LAT+1]));
    end

    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        held = p;
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
          a = A_W'($urandom); b = B_W'($urandom); vin = 1'($urandom);
          tick();
          chk("ce_hold", 32'(p), 32'(held));
        end
        ce = 1'b1;
      end
      a = A_W'($urandom); b = B_W'($urandom); vin = 1'($urandom);
      tick();
    end

    for (int i = 0; i < 2; i++) begin
      a = A_W'($urandom) | 8'h01; b = B_W'($urandom) | 8'h01; vin = 1'b1;
      tick();
    end
    rst = 1'b1;
    a = A_W'($urandom); b = B_W'($urandom); vin = 1'b1;
    tick();
    chk("rst_pulse", 32'(p), 32'd0);
    rst = 1'b0;

    pa = A_W'($urandom) | 8'h01;
    pb = B_W'($urandom) | 8'h01;
    for (int i = 0; i < LAT; i++) begin
      if (i == 0) begin a = pa; b = pb; vin = 1'b1; end
      else        begin a = '0; b = '0; vin = 1'b0; end
      tick();
      if (i < LAT - 1) chk("flush", 32'(p), 32'd0);
      else             chk("post_rst", 32'(p), 32'(ref_mul(pa, pb)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
